// File: rtl/icache_types_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Default geometry (ICACHE_NSETS) sizes the address overlay struct.
// Frame tags are stored at the widest possible width so that any NSETS >= 2 fits.
package icache_types_pkg;

    localparam int unsigned WORDW        = 32;
    localparam int unsigned BLKWORDS     = 2;
    localparam int unsigned ICACHE_NSETS = 8;
    localparam int unsigned ICACHE_IDXW  = $clog2(ICACHE_NSETS);
    localparam int unsigned ICACHE_TAGW  = WORDW - 3 - ICACHE_IDXW;
    localparam int unsigned TAG_MAXW     = WORDW - 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        FETCH1 = 2'd2
    } icache_state_t;

    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic                   blkoff;
        logic [1:0]             bytoff;
    } icache_addr_t;

    typedef struct packed {
        logic                               valid;
        logic [TAG_MAXW-1:0]                tag;
        logic [BLKWORDS-1:0][WORDW-1:0]     data;
    } icache_frame_t;

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
// slave: the cache; master: datapath plus memory controller.
interface icache_ctrl_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_frame_array.sv
// Valid/tag/data storage for the cache: one write port, one combinational read port.
// Only valid bits are reset; tag/data are qualified by valid.
module icache_frame_array
    import icache_types_pkg::*;
#(
    parameter int unsigned NSETS = ICACHE_NSETS,
    localparam int unsigned IDXW = $clog2(NSETS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                we,
    input  logic [IDXW-1:0]     widx,
    input  icache_frame_t       wframe,
    input  logic [IDXW-1:0]     ridx,
    output icache_frame_t       rframe
);

    logic [NSETS-1:0]                   valid_q;
    logic [TAG_MAXW-1:0]                tag_q  [NSETS];
    logic [BLKWORDS-1:0][WORDW-1:0]     data_q [NSETS];

    // Valid bits: cleared by reset, set by a frame write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[widx] <= wframe.valid;
        end
    end

    // Tag and data payload: whole frame written at once.
    always_ff @(posedge CLK) begin
        if (we && !RST) begin
            tag_q[widx]  <= wframe.tag;
            data_q[widx] <= wframe.data;
        end
    end

    // Combinational read of the addressed frame.
    always_comb begin
        rframe       = '0;
        rframe.valid = valid_q[ridx];
        rframe.tag   = tag_q[ridx];
        rframe.data  = data_q[ridx];
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with two-word block fill.
// Hits resolve in the request cycle; misses run IDLE -> FETCH0 -> FETCH1.
// Optional hit/miss statistics counters: define ICACHE_STATS_EN.
module icache_ctrl
    import icache_types_pkg::*;
#(
    parameter int unsigned NSETS = ICACHE_NSETS
) (
    input  logic                CLK,
    input  logic                RST,
    icache_ctrl_if.slave        bus,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam int unsigned IDXW = $clog2(NSETS);
    localparam int unsigned BLKW = WORDW - 3;

    icache_state_t          state;
    logic [BLKW-1:0]        base_blk;
    logic [WORDW-1:0]       word0_q;
    logic                   iren_q;
    logic [WORDW-1:0]       iaddr_q;

    icache_addr_t           req_a;
    logic [IDXW-1:0]        req_idx;
    logic [TAG_MAXW-1:0]    req_tag;
    icache_frame_t          rframe;
    icache_frame_t          wframe;
    logic                   hit_c;
    logic                   fill_done_c;
    logic                   unused_addr;

    // Request address decode; byte offset is ignored.
    assign req_a       = icache_addr_t'(bus.imemaddr);
    assign req_idx     = bus.imemaddr[3 +: IDXW];
    assign req_tag     = TAG_MAXW'(bus.imemaddr[WORDW-1 : 3+IDXW]);
    assign unused_addr = ^{req_a.tag, req_a.idx, req_a.bytoff};

    icache_frame_array #(.NSETS(NSETS)) u_frames (
        .CLK    (CLK),
        .RST    (RST),
        .we     (fill_done_c),
        .widx   (base_blk[IDXW-1:0]),
        .wframe (wframe),
        .ridx   (req_idx),
        .rframe (rframe)
    );

    // Lookup only in IDLE; a cycle with RST asserted never hits.
    assign hit_c       = (state == IDLE) && bus.imemREN && rframe.valid
                         && (rframe.tag == req_tag) && !RST;
    assign fill_done_c = (state == FETCH1) && !bus.iwait && !RST;

    assign bus.ihit     = hit_c;
    assign bus.imemload = hit_c ? rframe.data[req_a.blkoff] : '0;
    assign bus.iREN     = iren_q;
    assign bus.iaddr    = iaddr_q;

    // Frame written on fill completion: buffered first word plus the incoming one.
    always_comb begin
        wframe         = '0;
        wframe.valid   = 1'b1;
        wframe.tag     = TAG_MAXW'(base_blk[BLKW-1:IDXW]);
        wframe.data[0] = word0_q;
        wframe.data[1] = bus.iload;
    end

    // Fill FSM with registered memory request outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            base_blk <= '0;
            word0_q  <= '0;
            iren_q   <= 1'b0;
            iaddr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.imemREN && !hit_c) begin
                        base_blk <= bus.imemaddr[WORDW-1:3];
                        iren_q   <= 1'b1;
                        iaddr_q  <= {bus.imemaddr[WORDW-1:3], 3'b000};
                        state    <= FETCH0;
                    end
                end
                FETCH0: begin
                    if (!bus.iwait) begin
                        word0_q <= bus.iload;
                        iaddr_q <= {base_blk, 3'b100};
                        state   <= FETCH1;
                    end
                end
                FETCH1: begin
                    if (!bus.iwait) begin
                        iren_q  <= 1'b0;
                        iaddr_q <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    iren_q  <= 1'b0;
                    iaddr_q <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating hit-cycle and completed-fill counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_c && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (fill_done_c && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus random fetches.
// Expected data/latency/memory addresses come from a set/tag model of a direct-mapped cache.
module tb_icache_ctrl;
    import icache_types_pkg::*;

    localparam int unsigned NSETS = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 CLK = ~CLK;

    icache_ctrl_if mif();

    icache_ctrl #(.NSETS(NSETS)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (mif.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_addr_q[$];
    int          hits_seen   = 0;
    int          fixed_waits = 0;
    int          total_waits = 0;
    int          n_hits      = 0;
    int          n_fills     = 0;
    bit          m_valid [NSETS];
    logic [31:0] m_tag   [NSETS];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference cache: returns 1 on hit; on miss records the fill it must cause.
    function automatic bit model_access(logic [31:0] a);
        int unsigned blk = a / 8;
        int unsigned set = blk % NSETS;
        logic [31:0] tag = 32'(blk / NSETS);
        if (m_valid[set] && m_tag[set] == tag) return 1'b1;
        m_valid[set] = 1'b1;
        m_tag[set]   = tag;
        exp_addr_q.push_back(blk * 8);
        exp_addr_q.push_back(blk * 8 + 4);
        n_fills++;
        return 1'b0;
    endfunction

    // Monitor: every ihit cycle must match the next expected instruction.
    always @(negedge CLK) begin
        if (!RST) begin
            if (mif.ihit === 1'b1) begin
                hits_seen++;
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ihit: got ihit=1 required 0 (addr %h)", mif.imemaddr);
                end else begin
                    check("imemload", mif.imemload, exp_data_q.pop_front());
                end
            end else begin
                check("imemload_idle", mif.imemload, 32'h0);
            end
        end
    end

    // Memory controller model: waits per request, address order and stability checks.
    initial begin : mem_proc
        bit          busy;
        int          waits_left;
        logic [31:0] cur;
        busy = 0; waits_left = 0; cur = '0;
        mif.iwait = 1'b1;
        mif.iload = '0;
        forever begin
            @(posedge CLK); #1;
            if (mif.iREN === 1'b1) begin
                if (!busy) begin
                    busy = 1;
                    cur  = mif.iaddr;
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_iREN: got iaddr %h required no request", mif.iaddr);
                    end else begin
                        check("iaddr", mif.iaddr, exp_addr_q.pop_front());
                    end
                    waits_left = (fixed_waits >= 0) ? fixed_waits : int'($urandom_range(0, 2));
                    total_waits += waits_left;
                end else begin
                    check("iaddr_stable", mif.iaddr, cur);
                end
                if (waits_left > 0) begin
                    waits_left--;
                    mif.iwait = 1'b1;
                    mif.iload = $urandom;
                end else begin
                    mif.iwait = 1'b0;
                    mif.iload = mem_word(cur);
                    busy = 0;
                end
            end else begin
                busy = 0;
                if (!RST) check("iaddr_idle", mif.iaddr, 32'h0);
                mif.iwait = 1'($urandom_range(0, 1));
                mif.iload = $urandom;
            end
        end
    end

    task automatic apply_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        mif.imemREN = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
        exp_addr_q.delete();
        n_hits = 0;
        n_fills = 0;
        RST = 1'b0;
    endtask

    // Issue one fetch, hold it until ihit, report cycles from issue to hit.
    task automatic fetch(input logic [31:0] a, output int lat, output int exp_lat);
        bit h;
        int start_hits, start_waits, cyc;
        h = model_access(a);
        exp_data_q.push_back(mem_word(a));
        n_hits++;
        start_hits  = hits_seen;
        start_waits = total_waits;
        @(posedge CLK); #1;
        mif.imemREN  = 1'b1;
        mif.imemaddr = a;
        cyc = 0;
        do begin
            @(posedge CLK); #1;
            cyc++;
        end while (hits_seen == start_hits && cyc < 60);
        lat     = cyc;
        exp_lat = h ? 1 : 4 + (total_waits - start_waits);
        check("latency", 32'(lat), 32'(exp_lat));
        mif.imemREN  = 1'b0;
        mif.imemaddr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, 32'(n_hits));
        check("miss_count", miss_count, 32'(n_fills));
`else
        check("hit_count", hit_count, 32'h0);
        check("miss_count", miss_count, 32'h0);
`endif
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat, el, cyc, start_hits;
        bit h;
        RST = 1'b1;
        mif.imemREN  = 1'b0;
        mif.imemaddr = '0;
        apply_reset();

        // Reset state
        @(negedge CLK);
        check("rst_ihit", 32'(mif.ihit), 32'h0);
        check("rst_iREN", 32'(mif.iREN), 32'h0);
        check("rst_iaddr", mif.iaddr, 32'h0);
        check_stats();

        // Cold start, spatial hit, conflict eviction
        fixed_waits = 0;
        fetch(32'h0000_0000, lat, el);  check("cold_latency", 32'(lat), 32'd4);
        fetch(32'h0000_0004, lat, el);  check("spatial_latency", 32'(lat), 32'd1);
        fetch(32'h0000_0040, lat, el);  check("conflict_latency", 32'(lat), 32'd4);
        fetch(32'h0000_0000, lat, el);  check("evicted_latency", 32'(lat), 32'd4);

        // Redirect during FETCH0: 0x100 block completes, then 0x208 fills
        h = model_access(32'h0000_0100);
        h = model_access(32'h0000_0208);
        exp_data_q.push_back(mem_word(32'h0000_0208));
        n_hits++;
        start_hits = hits_seen;
        @(posedge CLK); #1;
        mif.imemREN  = 1'b1;
        mif.imemaddr = 32'h0000_0100;
        @(posedge CLK); #1;
        mif.imemaddr = 32'h0000_0208;
        cyc = 1;
        do begin
            @(posedge CLK); #1;
            cyc++;
        end while (hits_seen == start_hits && cyc < 60);
        check("redirect_latency", 32'(cyc), 32'd7);
        mif.imemREN = 1'b0;
        fetch(32'h0000_0100, lat, el);  check("redirect_block_hit", 32'(lat), 32'd1);
        check_stats();

        // Wait states: three in each fetch state
        apply_reset();
        fixed_waits = 3;
        fetch(32'h0000_0000, lat, el);  check("wait_latency", 32'(lat), 32'd10);
        fixed_waits = 0;

        // Reset asserted during FETCH1 with the last word being presented
        apply_reset();
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        @(posedge CLK); #1;
        mif.imemREN  = 1'b1;
        mif.imemaddr = 32'h0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        mif.imemREN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("midfill_rst_iREN", 32'(mif.iREN), 32'h0);
        check("midfill_rst_iaddr", mif.iaddr, 32'h0);
        check("midfill_rst_hit_count", hit_count, 32'h0);
        check("midfill_rst_miss_count", miss_count, 32'h0);
        fetch(32'h0000_0000, lat, el);  check("after_rst_latency", 32'(lat), 32'd4);

        // Random fetches with random memory waits
        fixed_waits = -1;
        for (int i = 0; i < 40; i++) begin
            fetch(32'($urandom_range(0, 255)) * 4, lat, el);
        end
        fixed_waits = 0;
        check_stats();

        @(posedge CLK); #1;
        check("leftover_hits", 32'(exp_data_q.size()), 32'h0);
        check("leftover_fills", 32'(exp_addr_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
